// File: rtl/bch_pkg.sv
// Shared BCH(15,7) t=2 constants, GF(2^4) tables and arithmetic, and the decoder state encoding.
package bch_pkg;

  localparam int N = 15;
  localparam int K = 7;
  localparam logic [8:0] GEN_POLY  = 9'h1D1;
  localparam logic [4:0] PRIM_POLY = 5'b10011;

  typedef logic [3:0] gf16_t;

  // ALPHA_POW[i] = a^i; GF_INV[x] = x^-1 (entry 0 is a don't-care, never selected)
  localparam logic [14:0][3:0] ALPHA_POW = {
    4'h9, 4'hD, 4'hF, 4'hE, 4'h7, 4'hA, 4'h5, 4'hB,
    4'hC, 4'h6, 4'h3, 4'h8, 4'h4, 4'h2, 4'h1
  };
  localparam logic [15:0][3:0] GF_INV = {
    4'h8, 4'h3, 4'h4, 4'hA, 4'h5, 4'hC, 4'h2, 4'hF,
    4'h6, 4'h7, 4'hB, 4'hD, 4'hE, 4'h9, 4'h1, 4'h0
  };

  typedef enum logic [2:0] {IDLE, SYND, SOLVE, CHIEN, OUT} dec_state_t;

  function automatic gf16_t gf16_mul(input gf16_t a, input gf16_t b);
    logic [6:0] p;
    p = '0;
    for (int i = 0; i < 4; i++)
      if (b[i]) p = p ^ (7'(a) << i);
    for (int i = 6; i >= 4; i--)
      if (p[i]) p = p ^ (7'(PRIM_POLY) << (i - 4));
    return p[3:0];
  endfunction

endpackage

// File: rtl/bch15_7_decoder_gf16_mul.sv
// Combinational GF(2^4) multiplier, zero latency, no flow control.
module bch_gf16_mul
  import bch_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [3:0] p
);

  assign p = gf16_mul(a, b);

endmodule

// File: rtl/bch15_7_decoder.sv
// BCH(15,7) t=2 serial decoder: syndromes, Peterson solve, Chien search; one word in flight, 31-cycle latency,
// result held until out_ready. Optional saturating statistics counters under BCH_DEC_STATS_EN.
module bch15_7_decoder
  import bch_pkg::*;
#(
  parameter bit PASS_UNCORR = 1'b1
`ifdef BCH_DEC_STATS_EN
  , parameter int STAT_W = 16
`endif
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   in_code,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N-1:0]   out_code,
  output logic [K-1:0]   out_data,
  output logic [1:0]     out_nerr,
  output logic           out_uncorr
`ifdef BCH_DEC_STATS_EN
  , output logic [STAT_W-1:0] stat_corr
  , output logic [STAT_W-1:0] stat_uncorr
`endif
);

  dec_state_t state, state_nx;

  logic [N-1:0] raw, code, code_nx;
  logic [3:0]   cnt;
  gf16_t        s1, s3, t1, t2;
  gf16_t        s1_sq, s1_cube, sig2_c, t1_nx, t2_nx;
  logic [1:0]   deg, roots, roots_nx;
  logic         fail, hit, unc;

  bch_gf16_mul u_sq   (.a(s1),           .b(s1),         .p(s1_sq));
  bch_gf16_mul u_cube (.a(s1_sq),        .b(s1),         .p(s1_cube));
  bch_gf16_mul u_sig2 (.a(s3 ^ s1_cube), .b(GF_INV[s1]), .p(sig2_c));
  bch_gf16_mul u_t1   (.a(t1),           .b(ALPHA_POW[14]), .p(t1_nx));
  bch_gf16_mul u_t2   (.a(t2),           .b(ALPHA_POW[13]), .p(t2_nx));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid)     state_nx = SYND;
      SYND:    if (cnt == 4'd0)  state_nx = SOLVE;
      SOLVE:                     state_nx = CHIEN;
      CHIEN:   if (cnt == 4'd14) state_nx = OUT;
      OUT:     if (out_ready)    state_nx = IDLE;
      default:                   state_nx = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == OUT);
  end

  // Locator evaluated at a^-i: 1 + sig1*a^-i + sig2*a^-2i, with t1/t2 stepped each cycle
  always_comb begin
    hit      = ((4'h1 ^ t1 ^ t2) == 4'h0);
    code_nx  = hit ? (code ^ (15'h1 << cnt)) : code;
    roots_nx = roots + {1'b0, hit};
    unc      = fail || (roots_nx != deg);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      raw        <= '0;
      code       <= '0;
      cnt        <= '0;
      s1         <= '0;
      s3         <= '0;
      t1         <= '0;
      t2         <= '0;
      deg        <= '0;
      roots      <= '0;
      fail       <= 1'b0;
      out_code   <= '0;
      out_nerr   <= '0;
      out_uncorr <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          raw  <= in_code;
          code <= in_code;
          s1   <= '0;
          s3   <= '0;
          cnt  <= 4'd14;
        end
        SYND: begin
          s1  <= gf16_mul(s1, ALPHA_POW[1]) ^ {3'b0, raw[cnt]};
          s3  <= gf16_mul(s3, ALPHA_POW[3]) ^ {3'b0, raw[cnt]};
          cnt <= cnt - 4'd1;
        end
        SOLVE: begin
          cnt   <= '0;
          roots <= '0;
          fail  <= (s1 == 4'h0) && (s3 != 4'h0);
          if (s1 == 4'h0) begin
            deg <= 2'd0;
            t1  <= '0;
            t2  <= '0;
          end else if (s3 == s1_cube) begin
            deg <= 2'd1;
            t1  <= s1;
            t2  <= '0;
          end else begin
            deg <= 2'd2;
            t1  <= s1;
            t2  <= sig2_c;
          end
        end
        CHIEN: begin
          code  <= code_nx;
          roots <= roots_nx;
          t1    <= t1_nx;
          t2    <= t2_nx;
          cnt   <= cnt + 4'd1;
          if (cnt == 4'd14) begin
            out_uncorr <= unc;
            out_nerr   <= unc ? 2'd0 : roots_nx;
            out_code   <= unc ? (PASS_UNCORR ? raw : '0) : code_nx;
          end
        end
        default: ;
      endcase
    end
  end

  assign out_data = out_code[N-1:N-K];

`ifdef BCH_DEC_STATS_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stat_corr   <= '0;
      stat_uncorr <= '0;
    end else if (out_valid && out_ready) begin
      if ((out_nerr != 2'd0) && (stat_corr != '1))  stat_corr   <= stat_corr + 1'b1;
      if (out_uncorr && (stat_uncorr != '1))         stat_uncorr <= stat_uncorr + 1'b1;
    end
  end
`endif

endmodule
